// File: rtl/mii_tx_scheduler.sv
// mii_tx_scheduler: round-robin arbiter sharing one MII transmit port between two byte-stream
// frame sources, adding preamble/SFD, nibble serialization, IPG, carrier deferral and underrun handling.
module mii_tx_scheduler #(
    parameter int IPG_NIBBLES      = 24,
    parameter int PREAMBLE_NIBBLES = 15
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        src0_valid,
    input  logic [7:0]  src0_data,
    input  logic        src0_sop,
    input  logic        src0_eop,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [7:0]  src1_data,
    input  logic        src1_sop,
    input  logic        src1_eop,
    output logic        src1_ready,
    input  logic        mii_crs,
    output logic [3:0]  mii_tx_d,
    output logic        mii_tx_en,
    output logic        mii_tx_err,
    output logic        active_src,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  underrun_count
);
    localparam int CMAX = IPG_NIBBLES > PREAMBLE_NIBBLES ? IPG_NIBBLES : PREAMBLE_NIBBLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, PRE, DATA, ERR, DISCARD, IPG} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    cur, cur_n;
    logic          hi, hi_n, last, last_n, act_n;
    logic          fetch, take, fc_inc, uc_inc;
    logic          req0, req1, g_valid, g_eop;
    logic [7:0]    g_data;
    logic [3:0]    d_n;

    assign req0    = src0_valid & src0_sop;
    assign req1    = src1_valid & src1_sop;
    assign g_valid = active_src ? src1_valid : src0_valid;
    assign g_eop   = active_src ? src1_eop : src0_eop;
    assign g_data  = active_src ? src1_data : src0_data;
    assign busy    = state != IDLE;
    assign take    = fetch | (state == DISCARD);
    // In IDLE only stray non-sop bytes are accepted (and dropped); the sop byte waits for the SFD fetch.
    assign src0_ready = state == IDLE ? src0_valid & ~src0_sop : take & ~active_src;
    assign src1_ready = state == IDLE ? src1_valid & ~src1_sop : take & active_src;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        hi_n    = hi;
        last_n  = last;
        act_n   = active_src;
        fetch   = 1'b0;
        fc_inc  = 1'b0;
        uc_inc  = 1'b0;
        case (state)
            IDLE: if ((req0 | req1) & ~mii_crs) begin
                state_n = PRE;
                cnt_n   = '0;
                act_n   = req0 & req1 ? ~active_src : req1;
            end
            PRE: if (cnt == CW'(PREAMBLE_NIBBLES)) fetch = 1'b1;
                 else cnt_n = cnt + 1'b1;
            DATA: if (!hi) hi_n = 1'b1;
                  else if (last) begin
                      state_n = IPG;
                      cnt_n   = '0;
                      fc_inc  = 1'b1;
                  end else fetch = 1'b1;
            ERR: if (cnt == CW'(1)) state_n = DISCARD;
                 else cnt_n = cnt + 1'b1;
            DISCARD: if (g_valid & g_eop) begin
                state_n = IPG;
                cnt_n   = '0;
                uc_inc  = 1'b1;
            end
            IPG: if (cnt == CW'(IPG_NIBBLES - 1)) state_n = IDLE;
                 else cnt_n = cnt + 1'b1;
            default: state_n = IDLE;
        endcase
        if (fetch) begin
            state_n = g_valid ? DATA : ERR;
            cnt_n   = '0;
            hi_n    = 1'b0;
            cur_n   = g_data;
            last_n  = g_eop;
        end
        // Wire outputs are registered from the next state so they line up with it.
        d_n = state_n == PRE  ? (cnt_n == CW'(PREAMBLE_NIBBLES) ? 4'hD : 4'h5) :
              state_n == DATA ? (hi_n ? cur_n[7:4] : cur_n[3:0]) : 4'h0;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            cur            <= '0;
            hi             <= 1'b0;
            last           <= 1'b0;
            active_src     <= 1'b1;
            mii_tx_d       <= '0;
            mii_tx_en      <= 1'b0;
            mii_tx_err     <= 1'b0;
            frame_count    <= '0;
            underrun_count <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cur            <= cur_n;
            hi             <= hi_n;
            last           <= last_n;
            active_src     <= act_n;
            mii_tx_d       <= d_n;
            mii_tx_en      <= state_n inside {PRE, DATA, ERR};
            mii_tx_err     <= state_n == ERR;
            frame_count    <= frame_count + 16'(fc_inc);
            underrun_count <= underrun_count + 8'(uc_inc & (underrun_count != 8'hFF));
        end
    end
endmodule

// File: tb/tb_mii_tx_scheduler.sv
// tb_mii_tx_scheduler: randomized frames per source; expected wire nibble sequences are queued
// when frames are issued and a monitor compares every tx_en burst against them.
module tb_mii_tx_scheduler;
    localparam int IPG = 24;
    localparam int PRE = 15;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       hole;
    } item_t;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crs = 1'b0;
    logic        sv0, ss0, se0, sv1, ss1, se1;
    logic [7:0]  sd0, sd1;
    logic        r0, r1, txen, txerr, act, busy;
    logic [3:0]  txd;
    logic [15:0] fc;
    logic [7:0]  uc;

    item_t       q0[$], q1[$];
    logic [4:0]  exp_codes[$];
    int          exp_len[$], exp_gap[$];
    bit          exp_trunc[$];
    logic [4:0]  cap[$];
    logic [15:0] exp_fc = '0;
    int          exp_uc = 0;
    int          n_chk = 0, n_pass = 0, n_exp = 0, frames_done = 0;
    bit          err_stray = 0;

    mii_tx_scheduler #(.IPG_NIBBLES(IPG), .PREAMBLE_NIBBLES(PRE)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .src0_valid(sv0), .src0_data(sd0), .src0_sop(ss0), .src0_eop(se0), .src0_ready(r0),
        .src1_valid(sv1), .src1_data(sd1), .src1_sop(ss1), .src1_eop(se1), .src1_ready(r1),
        .mii_crs(crs), .mii_tx_d(txd), .mii_tx_en(txen), .mii_tx_err(txerr),
        .active_src(act), .busy(busy), .frame_count(fc), .underrun_count(uc)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int got, input int want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    function automatic bq_t rbytes(input int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    // Reference: a frame is 15x5, D, then every byte low nibble first; an underrun at the fetch of
    // byte h replaces everything from byte h onward with two error nibbles of value 0.
    task automatic push_frame(input int s, input bq_t b, input int hole, input int gap, input bit trunc);
        int n = 0;
        int sent;
        for (int i = 0; i < b.size(); i++) begin
            item_t it;
            if (i == hole) begin
                it = '{d: 8'h00, sop: 1'b0, eop: 1'b0, hole: 1'b1};
                if (s == 0) q0.push_back(it); else q1.push_back(it);
            end
            it = '{d: b[i], sop: i == 0, eop: i == b.size() - 1, hole: 1'b0};
            if (s == 0) q0.push_back(it); else q1.push_back(it);
        end
        for (int i = 0; i < PRE; i++) begin exp_codes.push_back(5'h05); n++; end
        exp_codes.push_back(5'h0D); n++;
        sent = hole < 0 ? b.size() : hole;
        for (int i = 0; i < sent; i++) begin
            exp_codes.push_back({1'b0, b[i][3:0]});
            exp_codes.push_back({1'b0, b[i][7:4]});
            n += 2;
        end
        if (hole >= 0) begin exp_codes.push_back(5'h10); exp_codes.push_back(5'h10); n += 2; end
        exp_len.push_back(n);
        exp_gap.push_back(gap);
        exp_trunc.push_back(trunc);
        n_exp++;
        if (!trunc) begin
            if (hole < 0) exp_fc++;
            else if (exp_uc < 255) exp_uc++;
        end
    endtask

    task automatic end_frame(input int rl);
        int n, g, bad, ga, ea;
        bit tr;
        logic [4:0] e;
        frames_done++;
        if (exp_len.size() == 0) begin
            check(0, "unexpected_frame", cap.size(), 0);
            return;
        end
        n = exp_len.pop_front();
        tr = exp_trunc.pop_front();
        g = exp_gap.pop_front();
        bad = -1; ga = 0; ea = 0;
        for (int i = 0; i < n; i++) begin
            e = exp_codes.pop_front();
            if (i < cap.size() && cap[i] != e && bad < 0) begin bad = i; ga = cap[i]; ea = e; end
        end
        check(tr ? cap.size() <= n : cap.size() == n, "frame_len", cap.size(), n);
        check(bad < 0, $sformatf("frame_nibble[%0d]", bad), ga, ea);
        if (g >= 0) check(rl == g, "ipg_gap", rl, g);
    endtask

    // Monitor: collects {tx_err, tx_d} for each tx_en burst and the tx_en-low run before it.
    initial begin
        int low = 0, rise_low = 0;
        bit in_f = 0;
        forever begin
            @(posedge clk); #1;
            if (txerr && !txen) err_stray = 1;
            if (txen) begin
                if (!in_f) begin in_f = 1; cap.delete(); rise_low = low; end
                cap.push_back({txerr, txd});
            end else begin
                if (in_f) begin in_f = 0; end_frame(rise_low); low = 0; end
                low++;
            end
        end
    end

    // Source drivers: present queue heads on negedge, retire them when ready was seen.
    initial begin
        bit p0, p1;
        sv0 = 0; ss0 = 0; se0 = 0; sd0 = 0; sv1 = 0; ss1 = 0; se1 = 0; sd1 = 0;
        forever begin
            @(negedge clk);
            p0 = q0.size() > 0;
            p1 = q1.size() > 0;
            sv0 = p0 ? !q0[0].hole : 1'b0;
            ss0 = p0 ? q0[0].sop : 1'b0;
            se0 = p0 ? q0[0].eop : 1'b0;
            sd0 = p0 ? q0[0].d : 8'h00;
            sv1 = p1 ? !q1[1-1].hole : 1'b0;
            ss1 = p1 ? q1[0].sop : 1'b0;
            se1 = p1 ? q1[0].eop : 1'b0;
            sd1 = p1 ? q1[0].d : 8'h00;
            #4;
            if (p0 && q0.size() > 0 && r0) void'(q0.pop_front());
            if (p1 && q1.size() > 0 && r1) void'(q1.pop_front());
        end
    end

    task automatic wait_frames(input int budget);
        for (int i = 0; i < budget && frames_done < n_exp; i++) @(negedge clk);
        check(frames_done >= n_exp, "frames_timeout", frames_done, n_exp);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || q0.size() > 0 || q1.size() > 0) && k < 3000) begin @(negedge clk); k++; end
        check(!busy, "idle_timeout", busy, 0);
    endtask

    initial begin
        int k;
        bit bad;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(txen == 0 && txerr == 0 && txd == 0, "reset_wire", {txen, txerr, txd}, 0);
        check(fc == 0 && uc == 0, "reset_counters", {fc, uc}, 0);
        check(act == 1 && busy == 0, "reset_act_busy", {act, busy}, 2);
        rst = 0;

        // Happy path with fixed bytes.
        push_frame(0, '{8'h12, 8'h34, 8'h56, 8'h78}, -1, -1, 0);
        wait_frames(200);
        wait_idle();
        check(fc == exp_fc, "fc_single", fc, exp_fc);
        check(act == 0, "act_single", act, 0);

        // Tie from reset: src0, src1, then src0 again, all back-to-back.
        rst = 1;
        @(posedge clk);
        exp_fc = 0; exp_uc = 0;
        push_frame(0, rbytes($urandom_range(1, 6)), -1, -1, 0);
        push_frame(1, rbytes($urandom_range(1, 6)), -1, IPG + 1, 0);
        push_frame(0, rbytes($urandom_range(1, 6)), -1, IPG + 1, 0);
        @(negedge clk);
        rst = 0;
        wait_frames(600);
        wait_idle();
        check(fc == exp_fc, "fc_rr", fc, exp_fc);

        // Underrun at the fetch of byte 2 on src1.
        push_frame(1, rbytes(5), 2, -1, 0);
        wait_frames(300);
        wait_idle();
        check(uc == 8'(exp_uc), "uc_first", uc, exp_uc);
        check(fc == exp_fc, "fc_after_underrun", fc, exp_fc);

        // Carrier deferral.
        crs = 1;
        push_frame(0, rbytes(3), -1, -1, 0);
        bad = 0;
        repeat (30) begin
            @(negedge clk); #2;
            if (txen || r0) bad = 1;
        end
        check(!bad, "crs_defer", bad, 0);
        @(negedge clk);
        crs = 0;
        @(posedge clk); #1;
        check(txen == 1, "crs_release_grant", txen, 1);
        wait_frames(200);
        wait_idle();

        // Reset in the middle of DATA.
        push_frame(0, rbytes(8), -1, -1, 1);
        k = 0;
        while (!txen && k < 200) begin @(negedge clk); k++; end
        check(txen == 1, "tx_start", txen, 1);
        repeat (20) @(negedge clk);
        #1 rst = 1;
        q0.delete();
        @(posedge clk); #1;
        check(txen == 0 && txerr == 0, "reset_midframe_wire", {txen, txerr}, 0);
        check(fc == 0 && uc == 0, "reset_midframe_counters", {fc, uc}, 0);
        check(busy == 0 && act == 1, "reset_midframe_state", {busy, act}, 1);
        exp_fc = 0; exp_uc = 0;
        push_frame(0, rbytes($urandom_range(1, 5)), -1, -1, 0);
        push_frame(1, rbytes($urandom_range(1, 5)), -1, IPG + 1, 0);
        @(negedge clk);
        rst = 0;
        wait_frames(400);
        wait_idle();
        check(fc == exp_fc, "fc_after_reset", fc, exp_fc);

        // Stray non-sop byte in IDLE is accepted and dropped.
        @(posedge clk);
        q0.push_back('{d: 8'hA5, sop: 1'b0, eop: 1'b0, hole: 1'b0});
        @(negedge clk); #2;
        check(r0 == 1, "stray_ready", r0, 1);
        k = frames_done;
        repeat (40) @(negedge clk);
        check(frames_done == k && q0.size() == 0 && !busy, "stray_dropped", frames_done, k);

        // Underrun count saturation.
        for (int i = 0; i < 256; i++) push_frame(1, rbytes(2), 1, -1, 0);
        wait_frames(20000);
        wait_idle();
        check(uc == 8'(exp_uc), "uc_saturate", uc, exp_uc);
        check(fc == exp_fc, "fc_after_underruns", fc, exp_fc);

        // Frame counter wrap from a preloaded 0xFFFF.
        force dut.frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_count;
        @(negedge clk);
        check(fc == 16'hFFFF, "fc_preload", fc, 16'hFFFF);
        exp_fc = 16'hFFFF;
        push_frame(0, rbytes($urandom_range(1, 4)), -1, -1, 0);
        wait_frames(200);
        wait_idle();
        check(fc == exp_fc, "fc_wrap", fc, exp_fc);
        check(exp_len.size() == 0, "pending_frames", exp_len.size(), 0);
        check(!err_stray, "tx_err_without_en", err_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mii_tx_scheduler.md
# mii_tx_scheduler

Shares the HPS EMAC1 MII transmit pins (`enet1_rx_d_mii_tx_d`/`tx_en`/`tx_err`) between two fabric-side byte-stream frame sources.
- Arbitrates round-robin at frame boundaries.
- Inserts preamble/SFD and serializes bytes to nibbles, low nibble first.
- Enforces inter-packet gap and defers while carrier is sensed.
- On source underrun, signals the error on the wire and discards the rest of the frame.

Runs entirely in the MII TX clock domain (25 MHz, one nibble per cycle).

## Interface
Parameters:
- `IPG_NIBBLES`, 24 — minimum idle nibble cycles after a frame (96 bit times); legal range ≥ 2.
- `PREAMBLE_NIBBLES`, 15 — count of 0x5 nibbles before the SFD nibble 0xD.

Ports:
- `clk_clk` in 1 — single clock; all logic on rising edge.
- `reset_reset` in 1 — reset; synchronous, active-high.
- `src0_valid`, `src1_valid` in 1 — source byte valid.
- `src0_data`, `src1_data` in 8 — frame byte (destination MAC first, FCS included by source).
- `src0_sop`, `src1_sop` in 1 — first byte of frame.
- `src0_eop`, `src1_eop` in 1 — last byte of frame.
- `src0_ready`, `src1_ready` out 1 — byte accepted when `valid & ready`; combinational from state.
- `mii_crs` in 1 — carrier sense, already synchronized.
- `mii_tx_d` out 4 — registered.
- `mii_tx_en` out 1 — registered.
- `mii_tx_err` out 1 — registered.
- `active_src` out 1 — source owning the current or most recent frame.
- `busy` out 1 — high in any state other than IDLE.
- `frame_count` out 16 — frames completed without underrun; wraps 0xFFFF→0.
- `underrun_count` out 8 — underrun frames; saturates at 0xFF.

## Operation
States: IDLE, PRE, DATA, ERR, DISCARD, IPG.

**IDLE**
- Outputs: `tx_en=0`, `tx_err=0`, `tx_d=0`.
- A source presenting `valid & !sop` gets `ready=1`; the stray byte is dropped and nothing else happens.
- Requesters are sources with `valid & sop`. When at least one exists and `mii_crs=0`:
  - Grant round-robin: a single requester wins; on a tie, the source not in `active_src` wins.
  - `active_src` ← winner; go to PRE with nibble count 0.
- While `mii_crs=1`, no grant is made and the requester's `ready` stays 0.

**PRE**
- `tx_en=1`; drives `PREAMBLE_NIBBLES` cycles of 0x5, then one cycle of 0xD.
- The granted source's `ready=1` in the 0xD cycle (fetch of byte 0, which carries sop).

**DATA**
- Alternates low and high phases: low drives `byte[3:0]`, high drives `byte[7:4]`; `tx_en=1`.
- Granted `ready=1` in each high phase, except the high phase of the eop byte.
- After the high phase of the eop byte: `frame_count++`, go to IPG.

**Underrun** — a fetch cycle (the 0xD cycle or any fetching high phase) with granted `valid=0`:
- Go to ERR: 2 cycles of `tx_en=1`, `tx_err=1`, `tx_d=0`.
- Then go to DISCARD (`tx_en=0`); granted `ready=1` until a byte with eop is accepted; `underrun_count++` (saturating).
- Then go to IPG.

**Stray sop** — sop on a byte other than byte 0 is ignored and the byte is sent as data.

**IPG**
- `tx_en=0` for `IPG_NIBBLES` cycles; sop is not accepted; then go to IDLE.
- `mii_crs` is ignored during IPG.

The non-granted source always has `ready=0` outside IDLE.

**Reset**
- At the first edge with `reset_reset=1`: state=IDLE, all outputs 0, counters 0, `active_src=1` (so src0 wins the first tie).
- A frame interrupted by reset is truncated with no `tx_err`.

## Timing
Let T be the IDLE cycle that grants (relative to registered outputs).
- 0x5 nibbles on T+1..T+15; 0xD on T+16; `ready` at T+16.
- Byte N: low nibble at T+17+2N, high nibble at T+18+2N; fetch of byte N+1 at T+18+2N.
- For an L-byte frame, `tx_en` is high T+1..T+16+2L.
- IPG occupies T+17+2L..T+16+2L+IPG_NIBBLES; the next grant is at the earliest in the following IDLE cycle.
- Minimum `tx_en`-low gap between frames: `IPG_NIBBLES+1` cycles (25 at default).
- Underrun detected at fetch cycle F: `tx_err` is high F+1..F+2.

## Test plan
1. **Single frame, happy path.** src0 sends a 4-byte frame 0x12,0x34,0x56,0x78 → on `tx_d`: 15×0x5, 0xD, then 2,1,4,3,6,5,8,7; `tx_en` high for 24 cycles; `frame_count=1`; `tx_err` never high.
2. **Tie and round-robin.** Both sources hold sop from reset → src0 frame first, src1 next. The gap between them is exactly 25 `tx_en`-low cycles. A third frame from src0 is served after src1.
3. **Underrun.** src1 drops `valid` at byte 2 fetch → `tx_err`/`tx_en` high for 2 cycles with `tx_d=0`, then `tx_en=0`. Remaining bytes are drained through eop; `underrun_count=1`, `frame_count` unchanged.
4. **Carrier deferral.** `mii_crs=1` while src0 requests → no `tx_en` and `ready=0`. Grant occurs on the cycle `crs` falls; `tx_en` rises the next cycle.
5. **Reset mid-frame.** Reset asserted during DATA → the next edge gives `tx_en=0`, counters 0. After release, src0 wins a tie.
6. **Stray byte and counter boundaries.**
   - src0 `valid` without sop in IDLE → accepted and dropped, no transmission.
   - Preload `frame_count=0xFFFF` via 65535 frames (or force) → wraps to 0.
   - 256 underruns → `underrun_count` stays 0xFF.
